hi_sniff_decim: RTL and testbench

//   Upstream conditioning stage for the HF sniffer serializer. Takes raw 8-bit ADC samples
//   at the 13.56 MHz carrier rate and averages each window of 2^DECIM_LOG2 samples. Results
//   go into a small first-word-fall-through FIFO with a valid/ready handshake. The SSP

---
 rtl/hi_sniff_decim_if.sv | 24 ++
 rtl/hi_sniff_decim.sv | 151 +++++++++++++++
 tb/tb_hi_sniff_decim.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/hi_sniff_decim_if.sv
// Handshake bundle for hi_sniff_decim: the sample input side and the FWFT FIFO output side.
// The producer/consumer environment uses the master modport and the decimator uses the slave modport.
interface hi_sniff_decim_if #(
  parameter int FIFO_DEPTH_LOG2 = 2
);
  logic [7:0]               adc_d;
  logic                     adc_en;
  logic                     clear;
  logic [7:0]               out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [FIFO_DEPTH_LOG2:0] fill_level;
  logic                     overflow;

  modport master (
    output adc_d, adc_en, clear, out_ready,
    input  out_data, out_valid, fill_level, overflow
  );

  modport slave (
    input  adc_d, adc_en, clear, out_ready,
    output out_data, out_valid, fill_level, overflow
  );
endinterface

// File: rtl/hi_sniff_decim.sv
// Window decimator for HF sniffer ADC samples feeding a small FWFT FIFO with valid/ready pop.
// Define HI_SNIFF_PEAK_EN to emit the peak-to-peak value of each window instead of its truncated mean.
module hi_sniff_decim #(
  parameter int DECIM_LOG2      = 2,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input logic           ck_1356meg,
  input logic           reset_n,
  hi_sniff_decim_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0]   FULL_LEVEL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE    = FIFO_DEPTH_LOG2'(1);

  logic [DECIM_LOG2-1:0] count;
  logic                  last;
  logic [7:0]            result;

  assign last = bus.adc_en && (count == '1);

  always_ff @(posedge ck_1356meg or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (bus.clear) begin
      count <= '0;
    end else if (bus.adc_en) begin
      count <= count + 1'b1;
    end
  end

`ifdef HI_SNIFF_PEAK_EN
  logic [7:0] run_max;
  logic [7:0] run_min;
  logic [7:0] cur_max;
  logic [7:0] cur_min;

  always_comb begin
    cur_max = (bus.adc_d > run_max) ? bus.adc_d : run_max;
    cur_min = (bus.adc_d < run_min) ? bus.adc_d : run_min;
    result  = cur_max - cur_min;
  end

  // Extremes restart from the opposite rails so the first sample of a window always wins.
  always_ff @(posedge ck_1356meg or negedge reset_n) begin
    if (!reset_n) begin
      run_max <= 8'h00;
      run_min <= 8'hFF;
    end else if (bus.clear || last) begin
      run_max <= 8'h00;
      run_min <= 8'hFF;
    end else if (bus.adc_en) begin
      run_max <= cur_max;
      run_min <= cur_min;
    end
  end
`else
  logic [7+DECIM_LOG2:0] acc;
  logic [7+DECIM_LOG2:0] sum;
  logic [7+DECIM_LOG2:0] mean;

  // The extra DECIM_LOG2 bits hold a full window of 255s, so the sum never wraps.
  assign sum    = acc + {{DECIM_LOG2{1'b0}}, bus.adc_d};
  assign mean   = sum >> DECIM_LOG2;
  assign result = mean[7:0];

  always_ff @(posedge ck_1356meg or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (bus.clear || last) begin
      acc <= '0;
    end else if (bus.adc_en) begin
      acc <= sum;
    end
  end
`endif

  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_next;
  logic [FIFO_DEPTH_LOG2:0]   fill;
  logic [FIFO_DEPTH_LOG2:0]   fill_next;
  logic [7:0]                 head;
  logic [7:0]                 head_next;
  logic                       overflow_r;
  logic                       not_empty;
  logic                       full;
  logic                       push;
  logic                       pop;
  logic                       write_en;

  assign not_empty = (fill != '0);
  assign full      = (fill == FULL_LEVEL);
  assign push      = last && !bus.clear;
  assign pop       = not_empty && bus.out_ready && !bus.clear;
  assign write_en  = push && (!full || pop);
  assign rd_next   = pop ? rd_ptr + PTR_ONE : rd_ptr;

  // The head register is loaded with whatever will sit at rd_next, bypassing the array
  // when the slot being written is also the new head; it holds while the FIFO is empty.
  always_comb begin
    fill_next = fill;
    if (write_en && !pop) begin
      fill_next = fill + 1'b1;
    end else if (!write_en && pop) begin
      fill_next = fill - 1'b1;
    end
    head_next = head;
    if (fill_next != '0) begin
      head_next = (write_en && (rd_next == wr_ptr)) ? result : mem[rd_next];
    end
  end

  always_ff @(posedge ck_1356meg) begin
    if (write_en) begin
      mem[wr_ptr] <= result;
    end
  end

  always_ff @(posedge ck_1356meg or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      head       <= 8'h00;
      overflow_r <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (write_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      rd_ptr <= rd_next;
      fill   <= fill_next;
      head   <= head_next;
      if (push && full && !pop) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign bus.out_data   = head;
  assign bus.out_valid  = not_empty;
  assign bus.fill_level = fill;
  assign bus.overflow   = overflow_r;

endmodule

// File: tb/tb_hi_sniff_decim.sv
// Bench for hi_sniff_decim: directed scenarios followed by random traffic, all checked against
// a queue-based model of window results and FIFO contents (honours HI_SNIFF_PEAK_EN as well).
module tb_hi_sniff_decim;

  localparam int DECIM_LOG2      = 2;
  localparam int FIFO_DEPTH_LOG2 = 2;
  localparam int N               = 1 << DECIM_LOG2;
  localparam int DEPTH           = 1 << FIFO_DEPTH_LOG2;

  logic ck_1356meg = 1'b0;
  logic reset_n    = 1'b1;

  always #5 ck_1356meg = ~ck_1356meg;

  hi_sniff_decim_if #(.FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)) bus ();

  hi_sniff_decim #(
    .DECIM_LOG2     (DECIM_LOG2),
    .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) dut (
    .ck_1356meg(ck_1356meg),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  int         checks = 0;
  int         errors = 0;
  int         win[$];
  logic [7:0] model_q[$];
  logic       model_ovf  = 1'b0;
  logic [7:0] model_head = 8'h00;

  function automatic logic [7:0] window_result();
`ifdef HI_SNIFF_PEAK_EN
    int mx = 0;
    int mn = 255;
    foreach (win[i]) begin
      if (win[i] > mx) mx = win[i];
      if (win[i] < mn) mn = win[i];
    end
    return 8'(mx - mn);
`else
    int s = 0;
    foreach (win[i]) s += win[i];
    return 8'(s / N);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(model_q.size() > 0));
    chk({tag, " fill_level"}, 32'(bus.fill_level), 32'(model_q.size()));
    chk({tag, " overflow"}, 32'(bus.overflow), 32'(model_ovf));
    chk({tag, " out_data"}, 32'(bus.out_data), 32'(model_head));
  endtask

  task automatic model_reset();
    win.delete();
    model_q.delete();
    model_ovf  = 1'b0;
    model_head = 8'h00;
  endtask

  // One clock: drive inputs, advance the model with pre-edge state, then compare after the edge.
  task automatic applyStimulus(input logic en, input logic [7:0] d, input logic clr,
                               input logic rdy, input string tag);
    logic       pop;
    logic       push;
    logic [7:0] r;
    bus.adc_en    = en;
    bus.adc_d     = d;
    bus.clear     = clr;
    bus.out_ready = rdy;
    pop  = 1'b0;
    push = 1'b0;
    r    = 8'h00;
    if (clr) begin
      win.delete();
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      pop = (model_q.size() > 0) && rdy;
      if (en) begin
        win.push_back(int'(d));
        if (win.size() == N) begin
          r    = window_result();
          push = 1'b1;
          win.delete();
        end
      end
      if (pop) void'(model_q.pop_front());
      if (push) begin
        if (model_q.size() < DEPTH) model_q.push_back(r);
        else model_ovf = 1'b1;
      end
    end
    if (model_q.size() > 0) model_head = model_q[0];
    @(posedge ck_1356meg);
    #1;
    checkOutput(tag);
  endtask

  task automatic idle(input int n, input logic rdy, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, rdy, tag);
  endtask

  logic [7:0] s4 [4];

  initial begin
    bus.adc_en    = 1'b0;
    bus.adc_d     = 8'h00;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;

    #2 reset_n = 1'b0;
    #10;
    checkOutput("reset");
    reset_n = 1'b1;

    $display("[TB] continuous window 10,20,30,41");
    s4 = '{8'd10, 8'd20, 8'd30, 8'd41};
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, s4[i], 1'b0, 1'b1, "cont");
`ifdef HI_SNIFF_PEAK_EN
    chk("cont result", 32'(bus.out_data), 32'd31);
`else
    chk("cont result", 32'(bus.out_data), 32'd25);
`endif
    idle(1, 1'b1, "cont pop");

    $display("[TB] gapped window");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, s4[i], 1'b0, 1'b0, "gap");
      if (i < 3) idle(3, 1'b0, "gap idle");
    end
    idle(2, 1'b1, "gap drain");

    $display("[TB] overflow with 5 windows of 0x40");
    for (int w = 0; w < 5; w++)
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h40, 1'b0, 1'b0, "ovf fill");
    chk("ovf level", 32'(bus.fill_level), 32'd4);
    chk("ovf flag", 32'(bus.overflow), 32'd1);
    idle(5, 1'b1, "ovf drain");

    $display("[TB] push and pop on a full FIFO");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "full clear");
    for (int w = 0; w < 5; w++)
      for (int i = 0; i < 4; i++)
        applyStimulus(1'b1, 8'(16 * w + 4 * i), 1'b0, (w == 4 && i == 3), "full push");
    chk("full level", 32'(bus.fill_level), 32'd4);
    chk("full ovf", 32'(bus.overflow), 32'd0);
    idle(5, 1'b1, "full drain");

    $display("[TB] clear mid-window");
    applyStimulus(1'b1, 8'd200, 1'b0, 1'b0, "clr pre");
    applyStimulus(1'b1, 8'd100, 1'b0, 1'b0, "clr pre");
    applyStimulus(1'b1, 8'd99, 1'b1, 1'b0, "clr");
    s4 = '{8'd4, 8'd4, 8'd8, 8'd8};
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, s4[i], 1'b0, 1'b0, "clr post");
`ifdef HI_SNIFF_PEAK_EN
    chk("clr result", 32'(bus.out_data), 32'd4);
`else
    chk("clr result", 32'(bus.out_data), 32'd6);
`endif
    chk("clr level", 32'(bus.fill_level), 32'd1);

    $display("[TB] reset mid-window");
    applyStimulus(1'b1, 8'd77, 1'b0, 1'b0, "rst pre");
    applyStimulus(1'b1, 8'd66, 1'b0, 1'b0, "rst pre");
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    checkOutput("rst async");
    @(negedge ck_1356meg);
    reset_n = 1'b1;

    $display("[TB] window 10,200,30,50");
    s4 = '{8'd10, 8'd200, 8'd30, 8'd50};
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, s4[i], 1'b0, 1'b0, "peak");
`ifdef HI_SNIFF_PEAK_EN
    chk("peak result", 32'(bus.out_data), 32'd190);
`else
    chk("peak result", 32'(bus.out_data), 32'd72);
`endif
    idle(2, 1'b1, "peak drain");

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 9) < 7), 8'($urandom_range(0, 255)),
                    ($urandom_range(0, 99) < 2), ($urandom_range(0, 3) == 0), "rand");
    end
    idle(6, 1'b1, "rand drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
